// File: rtl/local_history_predictor.sv
// Local-history branch predictor: per-PC history table (LHT) selects a saturating
// counter in the pattern table (LPT); one branch in flight via lookup/resolve/update FSM.
module local_history_predictor #(
    parameter int unsigned PC_IDX_W = 10,
    parameter int unsigned HIST_W   = 10,
    parameter int unsigned CTR_W    = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic [PC_IDX_W-1:0] pc_index,
    output logic                req_ready,
    input  logic                resolve_valid,
    input  logic                BranchTaken,
    output logic                pred_valid,
    output logic                LPresult,
    output logic [HIST_W-1:0]   lhist_out
);

    localparam int unsigned LHT_DEPTH = 2 ** PC_IDX_W;
    localparam int unsigned LPT_DEPTH = 2 ** HIST_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_MIN = '0;

    typedef enum logic [2:0] {
        IDLE,
        LHT_RD,
        LPT_RD,
        PRED,
        UPD
    } state_e;

    state_e              state_q, state_d;
    logic [PC_IDX_W-1:0] idx_q, idx_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic                taken_q, taken_d;
    logic                req_ready_q, req_ready_d;
    logic                pred_valid_q, pred_valid_d;
    logic                lpresult_q, lpresult_d;
    logic [HIST_W-1:0]   lhist_q, lhist_d;

    logic [HIST_W-1:0]   lht_q [LHT_DEPTH];
    logic [CTR_W-1:0]    lpt_q [LPT_DEPTH];

    logic                tbl_we;
    logic [HIST_W-1:0]   lht_wdata;
    logic [CTR_W-1:0]    lpt_wdata;

    // Next-state, table write data and registered-output precompute
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hist_d    = hist_q;
        ctr_d     = ctr_q;
        taken_d   = taken_q;
        tbl_we    = 1'b0;
        lht_wdata = {hist_q[HIST_W-2:0], taken_q};
        if (taken_q) begin
            lpt_wdata = (ctr_q == CTR_MAX) ? ctr_q : ctr_q + CTR_W'(1);
        end else begin
            lpt_wdata = (ctr_q == CTR_MIN) ? ctr_q : ctr_q - CTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d   = pc_index;
                    state_d = LHT_RD;
                end
            end
            LHT_RD: begin
                hist_d  = lht_q[idx_q];
                state_d = LPT_RD;
            end
            LPT_RD: begin
                ctr_d   = lpt_q[hist_q];
                state_d = PRED;
            end
            PRED: begin
                if (resolve_valid) begin
                    taken_d = BranchTaken;
                    state_d = UPD;
                end
            end
            UPD: begin
                tbl_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are flopped from the next state so they line up with state_q
        req_ready_d  = (state_d == IDLE);
        pred_valid_d = (state_d == PRED);
        lpresult_d   = pred_valid_d ? ctr_d[CTR_W-1] : 1'b0;
        lhist_d      = pred_valid_d ? hist_d : lhist_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            hist_q       <= '0;
            ctr_q        <= '0;
            taken_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            pred_valid_q <= 1'b0;
            lpresult_q   <= 1'b0;
            lhist_q      <= '0;
            for (int i = 0; i < LHT_DEPTH; i++) lht_q[i] <= '0;
            for (int j = 0; j < LPT_DEPTH; j++) lpt_q[j] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hist_q       <= hist_d;
            ctr_q        <= ctr_d;
            taken_q      <= taken_d;
            req_ready_q  <= req_ready_d;
            pred_valid_q <= pred_valid_d;
            lpresult_q   <= lpresult_d;
            lhist_q      <= lhist_d;
            if (tbl_we) begin
                lht_q[idx_q]  <= lht_wdata;
                lpt_q[hist_q] <= lpt_wdata;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign pred_valid = pred_valid_q;
    assign LPresult   = lpresult_q;
    assign lhist_out  = lhist_q;

endmodule

// File: tb/tb_local_history_predictor.sv
// Self-checking bench for local_history_predictor: reference table model feeds a
// scoreboard of expected {LPresult, lhist_out} popped when pred_valid rises.
module tb_local_history_predictor;

    localparam int unsigned PC_IDX_W = 10;
    localparam int unsigned HIST_W   = 10;
    localparam int unsigned CTR_W    = 3;

    logic                clock = 1'b0;
    logic                reset;
    logic                req_valid;
    logic [PC_IDX_W-1:0] pc_index;
    logic                req_ready;
    logic                resolve_valid;
    logic                BranchTaken;
    logic                pred_valid;
    logic                LPresult;
    logic [HIST_W-1:0]   lhist_out;

    int total = 0;
    int bad   = 0;

    logic [HIST_W-1:0] m_lht [1024];
    int                m_lpt [1024];
    logic [HIST_W:0]   sb_q [$];

    local_history_predictor #(
        .PC_IDX_W(PC_IDX_W),
        .HIST_W  (HIST_W),
        .CTR_W   (CTR_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .pc_index     (pc_index),
        .req_ready    (req_ready),
        .resolve_valid(resolve_valid),
        .BranchTaken  (BranchTaken),
        .pred_valid   (pred_valid),
        .LPresult     (LPresult),
        .lhist_out    (lhist_out)
    );

    always #5 clock = ~clock;

    task automatic model_clear();
        for (int i = 0; i < 1024; i++) begin
            m_lht[i] = '0;
            m_lpt[i] = 0;
        end
    endtask

    task automatic model_update(input int idx, input logic taken);
        logic [HIST_W-1:0] h;
        h = m_lht[idx];
        if (taken) m_lpt[h] = (m_lpt[h] >= 7) ? 7 : m_lpt[h] + 1;
        else       m_lpt[h] = (m_lpt[h] <= 0) ? 0 : m_lpt[h] - 1;
        m_lht[idx] = {h[HIST_W-2:0], taken};
    endtask

    function automatic logic [HIST_W:0] model_expect(input int idx);
        logic [HIST_W-1:0] h;
        logic              p;
        h = m_lht[idx];
        p = (m_lpt[h] >= 4);
        return {p, h};
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; req_valid = 1'b0; resolve_valid = 1'b0; BranchTaken = 1'b0; pc_index = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        sb_q.delete();
    endtask

    // Full lookup/resolve transaction with scoreboard check of the prediction
    task automatic do_branch(input int idx, input logic taken, input string name);
        logic [HIST_W:0] exp_v;
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        total++;
        if (!req_ready) begin
            bad++;
            $display("FAIL %s ready_timeout: req_ready=%0b required 1", name, req_ready);
        end
        sb_q.push_back(model_expect(idx));
        req_valid = 1'b1; pc_index = PC_IDX_W'(idx);
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (!pred_valid && n < 20) begin @(negedge clock); n++; end
        exp_v = sb_q.pop_front();
        total++;
        if (!pred_valid) begin
            bad++;
            $display("FAIL %s pred_timeout: pred_valid=%0b required 1", name, pred_valid);
        end else if ({LPresult, lhist_out} !== exp_v) begin
            bad++;
            $display("FAIL %s pred: LPresult=%0b lhist=0x%03h required LPresult=%0b lhist=0x%03h",
                     name, LPresult, lhist_out, exp_v[HIST_W], exp_v[HIST_W-1:0]);
        end
        resolve_valid = 1'b1; BranchTaken = taken;
        @(negedge clock);
        resolve_valid = 1'b0;
        model_update(idx, taken);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({req_ready, pred_valid, LPresult, lhist_out} !== {1'b1, 1'b0, 1'b0, 10'h000}) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%0b pv=%0b lp=%0b lh=0x%03h required 1 0 0 0x000",
                     req_ready, pred_valid, LPresult, lhist_out);
        end
    endtask

    task automatic test_latency();
        int lows;
        logic [HIST_W:0] exp_v;
        lows = 0;
        sb_q.push_back(model_expect(5));
        req_valid = 1'b1; pc_index = 10'd5;
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            if (!req_ready) lows++;
            total++;
            if (pred_valid !== 1'b0) begin
                bad++;
                $display("FAIL latency_early_pv cycle%0d: pred_valid=%0b required 0", c, pred_valid);
            end
            @(negedge clock);
        end
        if (!req_ready) lows++;
        exp_v = sb_q.pop_front();
        total++;
        if ({pred_valid, LPresult, lhist_out} !== {1'b1, exp_v}) begin
            bad++;
            $display("FAIL latency_pred cycle3: pv=%0b lp=%0b lh=0x%03h required 1 %0b 0x%03h",
                     pred_valid, LPresult, lhist_out, exp_v[HIST_W], exp_v[HIST_W-1:0]);
        end
        resolve_valid = 1'b1; BranchTaken = 1'b0;
        @(negedge clock);
        resolve_valid = 1'b0;
        model_update(5, 1'b0);
        if (!req_ready) lows++;
        total++;
        if (pred_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_upd_pv: pred_valid=%0b required 0", pred_valid);
        end
        @(negedge clock);
        total++;
        if (req_ready !== 1'b1 || lows != 4) begin
            bad++;
            $display("FAIL latency_ready: req_ready=%0b low_cycles=%0d required 1 and 4", req_ready, lows);
        end
    endtask

    task automatic test_not_taken();
        for (int k = 0; k < 3; k++) do_branch(5, 1'b0, "not_taken");
    endtask

    task automatic test_taken_train();
        for (int k = 0; k < 14; k++) do_branch(5, 1'b1, "taken_train");
        do_branch(5, 1'b1, "taken_15th");
        for (int k = 0; k < 4; k++) do_branch(5, 1'b1, "taken_sat");
        // One not-taken then ten taken returns history to 0x3FF; 7->6 keeps MSB, a wrap would not
        do_branch(5, 1'b0, "sat_dec");
        for (int k = 0; k < 10; k++) do_branch(5, 1'b1, "sat_refill");
        do_branch(5, 1'b1, "sat_probe");
    endtask

    task automatic test_ignored();
        int n;
        logic [HIST_W:0] exp_v;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        sb_q.push_back(model_expect(7));
        req_valid = 1'b1; pc_index = 10'd7;
        @(negedge clock);
        req_valid = 1'b0;
        resolve_valid = 1'b1; BranchTaken = 1'b1;
        @(negedge clock);
        resolve_valid = 1'b0;
        n = 0;
        while (!pred_valid && n < 20) begin @(negedge clock); n++; end
        exp_v = sb_q.pop_front();
        total++;
        if ({pred_valid, LPresult, lhist_out} !== {1'b1, exp_v}) begin
            bad++;
            $display("FAIL ignored_pred: pv=%0b lp=%0b lh=0x%03h required 1 %0b 0x%03h",
                     pred_valid, LPresult, lhist_out, exp_v[HIST_W], exp_v[HIST_W-1:0]);
        end
        req_valid = 1'b1; pc_index = 10'd8;
        @(negedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clock);
        total++;
        if ({pred_valid, req_ready, LPresult, lhist_out} !== {1'b1, 1'b0, exp_v}) begin
            bad++;
            $display("FAIL ignored_hold: pv=%0b rdy=%0b lp=%0b lh=0x%03h required 1 0 %0b 0x%03h",
                     pred_valid, req_ready, LPresult, lhist_out, exp_v[HIST_W], exp_v[HIST_W-1:0]);
        end
        resolve_valid = 1'b1; BranchTaken = 1'b1;
        @(negedge clock);
        resolve_valid = 1'b0;
        model_update(7, 1'b1);
        do_branch(7, 1'b0, "ignored_idx7");
        do_branch(8, 1'b0, "ignored_idx8");
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        req_valid = 1'b1; pc_index = 10'd9;
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (!pred_valid && n < 20) begin @(negedge clock); n++; end
        resolve_valid = 1'b1; BranchTaken = 1'b1; reset = 1'b1;
        @(negedge clock);
        resolve_valid = 1'b0; reset = 1'b0;
        model_clear();
        total++;
        if ({req_ready, pred_valid, LPresult, lhist_out} !== {1'b1, 1'b0, 1'b0, 10'h000}) begin
            bad++;
            $display("FAIL reset_mid: rdy=%0b pv=%0b lp=%0b lh=0x%03h required 1 0 0 0x000",
                     req_ready, pred_valid, LPresult, lhist_out);
        end
        do_branch(9, 1'b1, "reset_mid_idx9");
        do_branch(5, 1'b1, "reset_mid_idx5");
    endtask

    task automatic test_interleave();
        do_branch(3, 1'b1, "interleave_a3");
        do_branch(4, 1'b0, "interleave_a4");
        do_branch(3, 1'b1, "interleave_b3");
        do_branch(4, 1'b0, "interleave_b4");
        do_branch(3, 1'b0, "interleave_c3");
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; resolve_valid = 1'b0; BranchTaken = 1'b0; pc_index = '0;
        model_clear();
        test_reset();
        test_latency();
        test_not_taken();
        test_taken_train();
        test_ignored();
        test_reset_mid();
        test_interleave();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: entries=%0d required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
